// File: rtl/round_judge.sv
// Quiz-round arbiter: opens on START, judges player answers, holds the verdict until RES_ACK.
// Outputs are all registered; a decision in cycle k is visible in cycle k+1.
module round_judge #(
  parameter int unsigned NPLAYER     = 2,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned IDX_W       = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [NPLAYER-1:0] ANS_VALID,
  input  logic [NPLAYER-1:0] ANS_OK,
  input  logic               RES_ACK,
  output logic               RES_VALID,
  output logic [1:0]         RESULT,
  output logic [NPLAYER-1:0] WIN_VEC,
  output logic [IDX_W-1:0]   WINNER,
  output logic [NPLAYER-1:0] LOCKOUT,
  output logic               BUSY
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [CntW-1:0]    CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0]    CntLast = CntW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);
  localparam logic [NPLAYER-1:0] VecOne  = NPLAYER'(1);

  localparam logic [1:0] ResNone    = 2'b00;
  localparam logic [1:0] ResWin     = 2'b01;
  localparam logic [1:0] ResTimeout = 2'b10;
  localparam logic [1:0] ResDraw    = 2'b11;

  typedef enum logic [1:0] {StIdle, StArmed, StHold} state_e;

  state_e              state_q, state_d;
  logic [NPLAYER-1:0]  lockout_q, lockout_d;
  logic [NPLAYER-1:0]  win_vec_q, win_vec_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [1:0]          result_q, result_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [NPLAYER-1:0]  counted;
  logic [NPLAYER-1:0]  correct;
  logic [NPLAYER-1:0]  lock_next;
  logic                single_win;
  logic                timeout_hit;
  logic [CntW-1:0]     cnt_inc;
  logic [IDX_W-1:0]    low_idx;

  // Locked-out players are invisible; their bits cannot add to correct or to lockout.
  assign counted     = ANS_VALID & ~lockout_q;
  assign correct     = counted & ANS_OK;
  assign lock_next   = lockout_q | (counted & ~ANS_OK);
  assign single_win  = ((correct & (correct - VecOne)) == '0);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CntLast);
  assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    low_idx = '0;
    for (int i = int'(NPLAYER) - 1; i >= 0; i--) begin
      if (correct[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lockout_d = lockout_q;
    win_vec_d = win_vec_q;
    winner_d  = winner_q;
    result_d  = result_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d   = StArmed;
          lockout_d = '0;
          cnt_d     = '0;
        end
      end

      StArmed: begin
        if (START) begin
          lockout_d = '0;
          cnt_d     = '0;
        end else begin
          lockout_d = lock_next;
          if (correct != '0) begin
            state_d   = StHold;
            result_d  = single_win ? ResWin : ResDraw;
            win_vec_d = correct;
            winner_d  = low_idx;
          end else if (&lock_next) begin
            state_d   = StHold;
            result_d  = ResNone;
            win_vec_d = '0;
            winner_d  = '0;
          end else if (timeout_hit) begin
            state_d   = StHold;
            result_d  = ResTimeout;
            win_vec_d = '0;
            winner_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      StHold: begin
        if (RES_ACK) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      lockout_q <= '0;
      win_vec_q <= '0;
      winner_q  <= '0;
      result_q  <= ResNone;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lockout_q <= lockout_d;
      win_vec_q <= win_vec_d;
      winner_q  <= winner_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  assign RES_VALID = (state_q == StHold);
  assign BUSY      = (state_q == StArmed);
  assign RESULT    = result_q;
  assign WIN_VEC   = win_vec_q;
  assign WINNER    = winner_q;
  assign LOCKOUT   = lockout_q;

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge (NPLAYER=4, TIMEOUT_CYC=8): round model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_round_judge;

  localparam int NP = 4;
  localparam int TO = 8;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [NP-1:0] ANS_VALID;
  logic [NP-1:0] ANS_OK;
  logic          RES_ACK;
  logic          RES_VALID;
  logic [1:0]    RESULT;
  logic [NP-1:0] WIN_VEC;
  logic [2:0]    WINNER;
  logic [NP-1:0] LOCKOUT;
  logic          BUSY;

  round_judge #(
    .NPLAYER    (NP),
    .TIMEOUT_CYC(TO),
    .IDX_W      (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .ANS_VALID(ANS_VALID),
    .ANS_OK   (ANS_OK),
    .RES_ACK  (RES_ACK),
    .RES_VALID(RES_VALID),
    .RESULT   (RESULT),
    .WIN_VEC  (WIN_VEC),
    .WINNER   (WINNER),
    .LOCKOUT  (LOCKOUT),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Round model: phase 0 idle, 1 armed, 2 holding a verdict.
  int            m_phase;
  int            m_armed;
  bit [NP-1:0]   m_lock;
  bit [NP-1:0]   m_win;
  bit [1:0]      m_res;
  int            m_winner;

  function automatic void m_reset();
    m_phase  = 0;
    m_armed  = 0;
    m_lock   = '0;
    m_win    = '0;
    m_res    = 2'b00;
    m_winner = 0;
  endfunction

  function automatic void model_step(input bit s, input bit [NP-1:0] av, input bit [NP-1:0] ok,
                                     input bit ack);
    int          n_right;
    bit [NP-1:0] right;
    bit [NP-1:0] locks;
    if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_lock  = '0;
        m_armed = 0;
      end
    end else if (m_phase == 1) begin
      if (s) begin
        m_lock  = '0;
        m_armed = 0;
      end else begin
        m_armed++;
        n_right = 0;
        right   = '0;
        locks   = m_lock;
        for (int i = 0; i < NP; i++) begin
          if (av[i] && !m_lock[i]) begin
            if (ok[i]) begin
              right[i] = 1'b1;
              n_right++;
            end else begin
              locks[i] = 1'b1;
            end
          end
        end
        m_lock = locks;
        if (n_right > 0) begin
          m_phase  = 2;
          m_res    = (n_right == 1) ? 2'b01 : 2'b11;
          m_win    = right;
          m_winner = 0;
          for (int i = NP - 1; i >= 0; i--) if (right[i]) m_winner = i;
        end else if (locks == '1 || m_armed == TO) begin
          m_phase  = 2;
          m_res    = (locks == '1) ? 2'b00 : 2'b10;
          m_win    = '0;
          m_winner = 0;
        end
      end
    end else begin
      if (ack) m_phase = 0;
    end
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      n_tests++;
      if (RES_VALID !== (m_phase == 2) || BUSY !== (m_phase == 1) || RESULT !== m_res ||
          WIN_VEC !== m_win || int'(WINNER) != m_winner || LOCKOUT !== m_lock) begin
        n_fail++;
        $display("FAIL model t=%0t got rv=%b busy=%b res=%b win=%b wnr=%0d lock=%b need rv=%b busy=%b res=%b win=%b wnr=%0d lock=%b",
                 $time, RES_VALID, BUSY, RESULT, WIN_VEC, WINNER, LOCKOUT, m_phase == 2,
                 m_phase == 1, m_res, m_win, m_winner, m_lock);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit s, input bit [NP-1:0] av, input bit [NP-1:0] ok, input bit ack);
    START     = s;
    ANS_VALID = av;
    ANS_OK    = ok;
    RES_ACK   = ack;
    @(posedge CLK);
    if (!RST) m_reset();
    else model_step(s, av, ok, ack);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  // Assert reset between edges, check outputs before any clock, release after one edge.
  task automatic async_reset(input string tag);
    #2;
    RST = 1'b0;
    m_reset();
    #1;
    chk({tag, "_rv"}, int'(RES_VALID), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_res"}, int'(RESULT), 0);
    chk({tag, "_win"}, int'(WIN_VEC), 0);
    chk({tag, "_wnr"}, int'(WINNER), 0);
    chk({tag, "_lock"}, int'(LOCKOUT), 0);
    idle(1);
    RST = 1'b1;
  endtask

  task automatic single_win_round(input string tag);
    cycle(1'b1, '0, '0, 1'b0);
    idle(1);
    cycle(1'b0, 4'b0100, 4'b0100, 1'b0);
    chk({tag, "_rv"}, int'(RES_VALID), 1);
    chk({tag, "_res"}, int'(RESULT), 1);
    chk({tag, "_wnr"}, int'(WINNER), 2);
    chk({tag, "_win"}, int'(WIN_VEC), 4);
  endtask

  initial begin
    RST       = 1'b0;
    START     = 1'b0;
    ANS_VALID = '0;
    ANS_OK    = '0;
    RES_ACK   = 1'b0;
    m_reset();
    chk_en = 1'b1;
    idle(2);
    chk("reset_rv", int'(RES_VALID), 0);
    chk("reset_busy", int'(BUSY), 0);
    RST = 1'b1;
    idle(1);

    // Single winner, then START/answers ignored while holding, then ack.
    single_win_round("win1");
    cycle(1'b1, 4'b1111, 4'b1111, 1'b0);
    chk("hold_frozen_win", int'(WIN_VEC), 4);
    cycle(1'b0, '0, '0, 1'b1);
    chk("ack_rv", int'(RES_VALID), 0);
    chk("idle_keep_res", int'(RESULT), 1);
    cycle(1'b0, '0, '0, 1'b1);

    // Draw between players 1 and 3.
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b0, 4'b1010, 4'b1010, 1'b0);
    chk("draw_res", int'(RESULT), 3);
    chk("draw_win", int'(WIN_VEC), 10);
    chk("draw_wnr", int'(WINNER), 1);
    cycle(1'b0, '0, '0, 1'b1);

    // Lockout: locked player ignored, then everyone else wrong.
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    chk("lock_p0", int'(LOCKOUT), 1);
    cycle(1'b0, 4'b0001, 4'b0001, 1'b1);
    chk("locked_ignored", int'(BUSY), 1);
    cycle(1'b0, 4'b1110, 4'b0000, 1'b0);
    chk("allwrong_res", int'(RESULT), 0);
    chk("allwrong_lock", int'(LOCKOUT), 15);
    chk("allwrong_rv", int'(RES_VALID), 1);
    cycle(1'b0, '0, '0, 1'b1);

    // Correct beats a simultaneous wrong; the wrong one still locks.
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b0, 4'b0011, 4'b0010, 1'b0);
    chk("prio_res", int'(RESULT), 1);
    chk("prio_wnr", int'(WINNER), 1);
    chk("prio_lock", int'(LOCKOUT), 1);
    cycle(1'b0, '0, '0, 1'b1);

    // Timeout on the 8th armed cycle, not the 7th.
    cycle(1'b1, '0, '0, 1'b0);
    idle(TO - 1);
    chk("to_not_yet", int'(BUSY), 1);
    idle(1);
    chk("to_res", int'(RESULT), 2);
    chk("to_rv", int'(RES_VALID), 1);
    cycle(1'b0, '0, '0, 1'b1);

    // Correct answer on the expiry cycle wins.
    cycle(1'b1, '0, '0, 1'b0);
    idle(TO - 1);
    cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    chk("to_edge_res", int'(RESULT), 1);
    chk("to_edge_wnr", int'(WINNER), 0);
    cycle(1'b0, '0, '0, 1'b1);

    // Restart mid-round: answers that cycle ignored, full timeout budget again.
    cycle(1'b1, '0, '0, 1'b0);
    idle(5);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b0);
    chk("restart_lock", int'(LOCKOUT), 0);
    idle(TO - 1);
    chk("restart_busy", int'(BUSY), 1);
    idle(1);
    chk("restart_to", int'(RESULT), 2);
    cycle(1'b0, '0, '0, 1'b1);

    // Reset mid-ARMED, then a normal round.
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    async_reset("rst_armed");
    single_win_round("post_rst1");
    // Reset mid-HOLD, then a normal round.
    async_reset("rst_hold");
    single_win_round("post_rst2");
    cycle(1'b0, '0, '0, 1'b1);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_judge.md
ROUND_JUDGE -- requirements
Module: round_judge

Interface
REQ-001 Parameter NPLAYER, default 2, number of player answer channels, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 1000, number of ARMED cycles before timeout; 0 disables timeout.
REQ-003 Parameter IDX_W, default 3, width of WINNER index; SHALL satisfy 2^IDX_W >= NPLAYER.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-low.
REQ-006 START  input  1  one-cycle pulse that opens a round.
REQ-007 ANS_VALID  input  NPLAYER  bit i high means player i submits an answer this cycle.
REQ-008 ANS_OK  input  NPLAYER  bit i is the correctness of player i's answer; meaningful only when ANS_VALID[i]=1.
REQ-009 RES_ACK  input  1  consumer (HP manager) accepts the held result.
REQ-010 RES_VALID  output  1  result held and valid.
REQ-011 RESULT  output  2  00 no winner (all wrong), 01 single winner, 10 timeout, 11 draw.
REQ-012 WIN_VEC  output  NPLAYER  bit per player that answered correctly in the deciding cycle.
REQ-013 WINNER  output  IDX_W  lowest index set in WIN_VEC; 0 when WIN_VEC is zero.
REQ-014 LOCKOUT  output  NPLAYER  bit i high means player i answered wrong this round.
REQ-015 BUSY  output  1  high in ARMED.

Function
REQ-016 Three states SHALL exist: IDLE, ARMED, HOLD.
REQ-017 IDLE: START=1 -> ARMED next cycle, with LOCKOUT cleared and the timeout counter at 0; ANS_VALID is ignored.
REQ-018 ARMED: an answer from player i counts only if ANS_VALID[i]=1 and LOCKOUT[i]=0.
REQ-019 ARMED: a counted answer with ANS_OK[i]=0 SHALL set LOCKOUT[i] next cycle.
REQ-020 ARMED: if exactly one counted correct answer occurs in cycle k -> HOLD at k+1, RESULT=01, WIN_VEC one-hot, WINNER=i.
REQ-021 ARMED: if two or more counted correct answers occur in the same cycle -> HOLD, RESULT=11, WIN_VEC set for all of them, WINNER=lowest index.
REQ-022 A correct answer SHALL take priority over simultaneous wrong answers from other players in the same cycle; those wrong answers still set LOCKOUT.
REQ-023 ARMED: if every LOCKOUT bit would be 1 after the current cycle and no correct answer occurred -> HOLD, RESULT=00, WIN_VEC=0.
REQ-024 Timeout counter: increments each ARMED cycle that has no decision; width is ceil(log2(TIMEOUT_CYC+1)) bits; the counter saturates and never wraps.
REQ-025 Timeout: when the counter reaches TIMEOUT_CYC-1 with no decision in that cycle -> HOLD, RESULT=10, WIN_VEC=0; this is the TIMEOUT_CYC-th ARMED cycle.
REQ-026 A correct answer in the same cycle as expiry SHALL win over the timeout.
REQ-027 START in ARMED SHALL restart the round: LOCKOUT cleared, counter at 0, and answers in that cycle ignored.
REQ-028 HOLD: RES_VALID=1, and RESULT, WIN_VEC, WINNER and LOCKOUT stay frozen; START and ANS_VALID are ignored.
REQ-029 HOLD: RES_ACK=1 -> IDLE next cycle with RES_VALID=0; RES_ACK outside HOLD is ignored.
REQ-030 Latency: decision input in cycle k -> RES_VALID=1 in cycle k+1; there is no combinational path from inputs to outputs.
REQ-031 In IDLE, RESULT, WIN_VEC and WINNER retain the last result; LOCKOUT retains its value until the next START.

Reset
REQ-032 RST=0 SHALL immediately force IDLE, RES_VALID=0, RESULT=00, WIN_VEC=0, WINNER=0, LOCKOUT=0, BUSY=0 and the counter to 0, in any state.
REQ-033 Release of RST SHALL take effect at the next rising CLK edge; the round in progress is discarded.

Verification (NPLAYER=4, TIMEOUT_CYC=8)
REQ-034 START; 2 cycles later ANS_VALID=0100, ANS_OK=0100 -> next cycle RES_VALID=1, RESULT=01, WINNER=2, WIN_VEC=0100; RES_ACK -> IDLE.
REQ-035 START; ANS_VALID=1010 with ANS_OK=1010 in the same cycle -> RESULT=11, WIN_VEC=1010, WINNER=1.
REQ-036 START; ANS_VALID=0001, ANS_OK=0000 -> LOCKOUT=0001; player 0 later answers correct -> ignored; then ANS_VALID=1110, ANS_OK=0000 -> RESULT=00, LOCKOUT=1111.
REQ-037 START with no answers -> RESULT=10 after 8 ARMED cycles; repeat with a correct answer on the 8th cycle -> RESULT=01.
REQ-038 RST=0 asserted mid-ARMED and mid-HOLD -> all outputs zero asynchronously; START after release behaves per REQ-034.
